// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, ALU opcodes, ID_ctrl bit positions
// and the EX-slot action encoding used by id_ex_stage.
package pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // ID_ctrl = {brn, ld, use_imm}
    localparam int CTRL_USE_IMM = 0;
    localparam int CTRL_LD      = 1;
    localparam int CTRL_BRN     = 2;

    typedef enum logic [1:0] {
        SLOT_LOAD = 2'd0,
        SLOT_KILL = 2'd1,
        SLOT_HOLD = 2'd2
    } slot_act_e;

endpackage

// File: rtl/fwd_sel.sv
// One operand's bypass mux: MEM result beats WB result beats the stored value.
// With ID_EX_FWD_EN undefined the stored value passes straight through.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic [REGW-1:0] src_idx,
    input  logic [XLEN-1:0] stored_val,
    input  logic [REGW-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_val
);

`ifdef ID_EX_FWD_EN
    // Register 0 is hardwired, so it is never bypassed
    always_comb begin
        fwd_val = stored_val;
        if (src_idx == {REGW{1'b0}}) begin
            fwd_val = stored_val;
        end else if (src_idx == mem_rd) begin
            fwd_val = mem_data;
        end else if (src_idx == wb_rd) begin
            fwd_val = wb_data;
        end else begin
            fwd_val = stored_val;
        end
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^{src_idx, mem_rd, mem_data, wb_rd, wb_data};
    assign fwd_val      = stored_val;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand bypass and load-use / hazard stalling.
// Optional macro ID_EX_FWD_EN enables MEM/WB forwarding; otherwise hazards stall.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ID_valid,
    input  logic [XLEN-1:0] ID_pc,
    input  logic [REGW-1:0] ID_rs1,
    input  logic [REGW-1:0] ID_rs2,
    input  logic [REGW-1:0] ID_rd,
    input  logic [XLEN-1:0] ID_rs1_val,
    input  logic [XLEN-1:0] ID_rs2_val,
    input  logic [XLEN-1:0] ID_imm,
    input  logic [3:0]      ID_alu_op,
    input  logic [2:0]      ID_ctrl,
    input  logic [REGW-1:0] MEM_rd,
    input  logic [REGW-1:0] WB_rd,
    input  logic [XLEN-1:0] MEM_data,
    input  logic [XLEN-1:0] WB_data,
    input  logic            EX_hold,
    input  logic            EX_flush,
    output logic            EX_valid,
    output logic [XLEN-1:0] EX_a,
    output logic [XLEN-1:0] EX_b,
    output logic [XLEN-1:0] EX_a2,
    output logic [XLEN-1:0] EX_b2,
    output logic [3:0]      EX_alu_op,
    output logic            EX_brn,
    output logic            EX_ld,
    output logic [REGW-1:0] EX_rd,
    output logic            ID_stall
);

    logic            valid_r;
    logic            brn_r;
    logic            ld_r;
    logic            use_imm_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] rs1_val_r;
    logic [XLEN-1:0] rs2_val_r;
    logic [XLEN-1:0] imm_r;
    logic [REGW-1:0] rs1_r;
    logic [REGW-1:0] rs2_r;
    logic [REGW-1:0] rd_r;
    logic [3:0]      alu_op_r;

    logic [XLEN-1:0] fwd1_s;
    logic [XLEN-1:0] fwd2_s;
    logic            hazard_s;
    logic            live_s;
    slot_act_e       act_s;

    fwd_sel #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .src_idx    (rs1_r),
        .stored_val (rs1_val_r),
        .mem_rd     (MEM_rd),
        .mem_data   (MEM_data),
        .wb_rd      (WB_rd),
        .wb_data    (WB_data),
        .fwd_val    (fwd1_s)
    );

    fwd_sel #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .src_idx    (rs2_r),
        .stored_val (rs2_val_r),
        .mem_rd     (MEM_rd),
        .mem_data   (MEM_data),
        .wb_rd      (WB_rd),
        .wb_data    (WB_data),
        .fwd_val    (fwd2_s)
    );

`ifdef ID_EX_FWD_EN
    // Only a load still sitting in EX has no result to bypass yet
    assign hazard_s = valid_r & ld_r & (rd_r != {REGW{1'b0}}) & ID_valid &
                      ((ID_rs1 == rd_r) | (ID_rs2 == rd_r));
`else
    logic rs1_busy_s;
    logic rs2_busy_s;
    assign rs1_busy_s = (ID_rs1 != {REGW{1'b0}}) &
                        ((valid_r & (ID_rs1 == rd_r)) | (ID_rs1 == MEM_rd) | (ID_rs1 == WB_rd));
    assign rs2_busy_s = (ID_rs2 != {REGW{1'b0}}) &
                        ((valid_r & (ID_rs2 == rd_r)) | (ID_rs2 == MEM_rd) | (ID_rs2 == WB_rd));
    assign hazard_s   = ID_valid & (rs1_busy_s | rs2_busy_s);
`endif

    // Slot action and upstream stall, in flush > hold > hazard > capture order
    always_comb begin
        act_s    = SLOT_LOAD;
        ID_stall = 1'b0;
        if (EX_flush) begin
            act_s    = SLOT_KILL;
            ID_stall = 1'b0;
        end else if (EX_hold) begin
            act_s    = SLOT_HOLD;
            ID_stall = 1'b1;
        end else if (hazard_s) begin
            act_s    = SLOT_KILL;
            ID_stall = 1'b1;
        end else begin
            act_s    = SLOT_LOAD;
            ID_stall = 1'b0;
        end
    end

    assign live_s = (act_s == SLOT_LOAD) & ID_valid;

    // EX slot register; a held slot absorbs bypassed values so retiring data survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= 1'b0;
            brn_r     <= 1'b0;
            ld_r      <= 1'b0;
            use_imm_r <= 1'b0;
            pc_r      <= {XLEN{1'b0}};
            rs1_val_r <= {XLEN{1'b0}};
            rs2_val_r <= {XLEN{1'b0}};
            imm_r     <= {XLEN{1'b0}};
            rs1_r     <= {REGW{1'b0}};
            rs2_r     <= {REGW{1'b0}};
            rd_r      <= {REGW{1'b0}};
            alu_op_r  <= 4'd0;
        end else begin
            case (act_s)
                SLOT_HOLD: begin
                    rs1_val_r <= fwd1_s;
                    rs2_val_r <= fwd2_s;
                end
                SLOT_LOAD, SLOT_KILL: begin
                    valid_r   <= live_s;
                    brn_r     <= live_s & ID_ctrl[CTRL_BRN];
                    ld_r      <= live_s & ID_ctrl[CTRL_LD];
                    rd_r      <= live_s ? ID_rd : {REGW{1'b0}};
                    use_imm_r <= ID_ctrl[CTRL_USE_IMM];
                    pc_r      <= ID_pc;
                    rs1_val_r <= ID_rs1_val;
                    rs2_val_r <= ID_rs2_val;
                    imm_r     <= ID_imm;
                    rs1_r     <= ID_rs1;
                    rs2_r     <= ID_rs2;
                    alu_op_r  <= ID_alu_op;
                end
                default: begin
                    valid_r <= 1'b0;
                    brn_r   <= 1'b0;
                    ld_r    <= 1'b0;
                    rd_r    <= {REGW{1'b0}};
                end
            endcase
        end
    end

    assign EX_valid  = valid_r;
    assign EX_rd     = rd_r;
    assign EX_brn    = brn_r;
    assign EX_ld     = ld_r;
    assign EX_alu_op = alu_op_r;
    assign EX_a2     = fwd1_s;
    assign EX_b2     = fwd2_s;
    assign EX_a      = brn_r ? pc_r : fwd1_s;
    assign EX_b      = (brn_r | use_imm_r) ? imm_r : fwd2_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a slot-level behavioural model,
// plus directed scenarios with literal expectations.
module tb_id_ex_stage;
    import pipe_pkg::*;

`ifdef ID_EX_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ID_valid;
    logic [31:0] ID_pc;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic [4:0]  ID_rd;
    logic [31:0] ID_rs1_val;
    logic [31:0] ID_rs2_val;
    logic [31:0] ID_imm;
    logic [3:0]  ID_alu_op;
    logic [2:0]  ID_ctrl;
    logic [4:0]  MEM_rd;
    logic [4:0]  WB_rd;
    logic [31:0] MEM_data;
    logic [31:0] WB_data;
    logic        EX_hold;
    logic        EX_flush;
    logic        EX_valid;
    logic [31:0] EX_a;
    logic [31:0] EX_b;
    logic [31:0] EX_a2;
    logic [31:0] EX_b2;
    logic [3:0]  EX_alu_op;
    logic        EX_brn;
    logic        EX_ld;
    logic [4:0]  EX_rd;
    logic        ID_stall;

    id_ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_pc(ID_pc),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_rs1_val(ID_rs1_val), .ID_rs2_val(ID_rs2_val), .ID_imm(ID_imm),
        .ID_alu_op(ID_alu_op), .ID_ctrl(ID_ctrl), .MEM_rd(MEM_rd), .WB_rd(WB_rd),
        .MEM_data(MEM_data), .WB_data(WB_data), .EX_hold(EX_hold), .EX_flush(EX_flush),
        .EX_valid(EX_valid), .EX_a(EX_a), .EX_b(EX_b), .EX_a2(EX_a2), .EX_b2(EX_b2),
        .EX_alu_op(EX_alu_op), .EX_brn(EX_brn), .EX_ld(EX_ld), .EX_rd(EX_rd),
        .ID_stall(ID_stall)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        brn;
        logic        ld;
        logic        uimm;
    } slot_t;

    slot_t m;
    int    n_vec;
    int    n_bad;
    logic  exp_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v);
        if (FWD_ON && idx != 5'd0 && idx == MEM_rd) return MEM_data;
        if (FWD_ON && idx != 5'd0 && idx == WB_rd) return WB_data;
        return v;
    endfunction

    function automatic logic busy(input logic [4:0] idx);
        return idx != 5'd0 && ((m.valid && idx == m.rd) || idx == MEM_rd || idx == WB_rd);
    endfunction

    function automatic logic model_stall();
        logic haz;
        if (FWD_ON)
            haz = m.valid && m.ld && m.rd != 5'd0 && ID_valid && (ID_rs1 == m.rd || ID_rs2 == m.rd);
        else
            haz = ID_valid && (busy(ID_rs1) || busy(ID_rs2));
        if (EX_flush) return 1'b0;
        if (EX_hold) return 1'b1;
        return haz;
    endfunction

    // Compare current outputs with the model, advance the model over the edge
    task automatic step_cycle();
        logic [31:0] a2;
        logic [31:0] b2;
        #1;
        exp_stall = model_stall();
        a2 = fwd(m.rs1, m.v1);
        b2 = fwd(m.rs2, m.v2);
        chk("EX_valid", EX_valid, m.valid);
        chk("EX_rd", EX_rd, m.rd);
        chk("EX_brn", EX_brn, m.brn);
        chk("EX_ld", EX_ld, m.ld);
        chk("ID_stall", ID_stall, exp_stall);
        if (m.valid) begin
            chk("EX_a2", EX_a2, a2);
            chk("EX_b2", EX_b2, b2);
            chk("EX_a", EX_a, m.brn ? m.pc : a2);
            chk("EX_b", EX_b, (m.brn || m.uimm) ? m.imm : b2);
            chk("EX_alu_op", EX_alu_op, m.op);
        end
        if (rst) begin
            m = '0;
        end else if (EX_flush || (!EX_hold && exp_stall)) begin
            m.valid = 1'b0; m.rd = 5'd0; m.brn = 1'b0; m.ld = 1'b0;
        end else if (EX_hold) begin
            m.v1 = a2;
            m.v2 = b2;
        end else begin
            m.valid = ID_valid;
            m.pc    = ID_pc;
            m.rs1   = ID_rs1;
            m.rs2   = ID_rs2;
            m.rd    = ID_valid ? ID_rd : 5'd0;
            m.v1    = ID_rs1_val;
            m.v2    = ID_rs2_val;
            m.imm   = ID_imm;
            m.op    = ID_alu_op;
            m.brn   = ID_valid && ID_ctrl[CTRL_BRN];
            m.ld    = ID_valid && ID_ctrl[CTRL_LD];
            m.uimm  = ID_ctrl[CTRL_USE_IMM];
        end
        @(negedge clk);
    endtask

    task automatic idle();
        ID_valid = 1'b0; ID_pc = 32'd0; ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_rd = 5'd0;
        ID_rs1_val = 32'd0; ID_rs2_val = 32'd0; ID_imm = 32'd0; ID_alu_op = 4'd0;
        ID_ctrl = 3'd0; MEM_rd = 5'd0; WB_rd = 5'd0; MEM_data = 32'd0; WB_data = 32'd0;
        EX_hold = 1'b0; EX_flush = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [2:0] ctrl);
        ID_valid = 1'b1; ID_pc = 32'h1000 + {27'd0, rd}; ID_rs1 = rs1; ID_rs2 = rs2; ID_rd = rd;
        ID_rs1_val = v1; ID_rs2_val = v2; ID_imm = 32'hFFFF_FFF0; ID_alu_op = ALU_ADD;
        ID_ctrl = ctrl;
    endtask

    task automatic rand_inputs(input logic keep_id);
        if (!keep_id) begin
            ID_valid   = ($urandom_range(3, 0) != 0);
            ID_pc      = $urandom;
            ID_rs1     = 5'($urandom_range(7, 0));
            ID_rs2     = 5'($urandom_range(7, 0));
            ID_rd      = 5'($urandom_range(7, 0));
            ID_rs1_val = $urandom;
            ID_rs2_val = $urandom;
            ID_imm     = $urandom;
            ID_alu_op  = 4'($urandom_range(9, 0));
            ID_ctrl    = {($urandom_range(7, 0) == 0), ($urandom_range(3, 0) == 0),
                          1'($urandom_range(1, 0))};
        end
        MEM_rd   = 5'($urandom_range(7, 0));
        WB_rd    = 5'($urandom_range(7, 0));
        MEM_data = $urandom;
        WB_data  = $urandom;
        EX_hold  = ($urandom_range(5, 0) == 0);
        EX_flush = ($urandom_range(15, 0) == 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        exp_stall = 1'b0;
        m = '0;
        rst = 1'b1;
        idle();
        @(negedge clk);
        #1;
        chk("reset_valid", EX_valid, 32'd0);
        chk("reset_rd", EX_rd, 32'd0);
        chk("reset_stall", ID_stall, 32'd0);
        step_cycle();
        rst = 1'b0;
        step_cycle();

        // ADD x3 followed by a consumer of x3
        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 3'b000);
        step_cycle();
        set_id(5'd3, 5'd0, 5'd4, 32'h99, 32'd0, 3'b000);
        #1;
        chk("fwd_mem_stall", ID_stall, FWD_ON ? 32'd0 : 32'd1);
        step_cycle();
        idle();
        MEM_rd = 5'd3; MEM_data = 32'h10;
        #1;
        chk("fwd_mem_a2", FWD_ON ? EX_a2 : {31'd0, EX_valid}, FWD_ON ? 32'h10 : 32'd0);
        step_cycle();

        // MEM beats WB; index 0 reads stored value
        idle();
        set_id(5'd5, 5'd0, 5'd6, 32'h77, 32'h55, 3'b000);
        step_cycle();
        idle();
        MEM_rd = 5'd5; MEM_data = 32'h1; WB_rd = 5'd5; WB_data = 32'h2;
        #1;
        chk("mem_over_wb", EX_a2, FWD_ON ? 32'h1 : 32'h77);
        chk("zero_idx_b2", EX_b2, 32'h55);
        MEM_rd = 5'd0; MEM_data = 32'hDEAD; WB_rd = 5'd0; WB_data = 32'hBEEF;
        #1;
        chk("zero_mem_rd_b2", EX_b2, 32'h55);
        chk("no_match_a2", EX_a2, 32'h77);
        step_cycle();

        // Load-use bubble
        idle();
        set_id(5'd1, 5'd0, 5'd7, 32'd0, 32'd0, 3'b010);
        step_cycle();
        set_id(5'd0, 5'd7, 5'd8, 32'd0, 32'h42, 3'b000);
        #1;
        chk("lu_stall", ID_stall, 32'd1);
        step_cycle();
        #1;
        chk("lu_bubble_valid", EX_valid, 32'd0);
        chk("lu_release_stall", ID_stall, 32'd0);
        step_cycle();
        idle();
        #1;
        chk("lu_issue_valid", EX_valid, 32'd1);
        chk("lu_issue_rd", EX_rd, 32'd8);
        chk("lu_issue_b2", EX_b2, 32'h42);
        step_cycle();

        // Hold for three cycles while WB retires x2
        set_id(5'd2, 5'd0, 5'd9, 32'h11, 32'd0, 3'b000);
        step_cycle();
        idle();
        EX_hold = 1'b1; WB_rd = 5'd2; WB_data = 32'hAB;
        #1;
        chk("hold_stall", ID_stall, 32'd1);
        step_cycle();
        WB_rd = 5'd0; WB_data = 32'd0;
        step_cycle();
        step_cycle();
        EX_hold = 1'b0;
        #1;
        chk("hold_valid", EX_valid, 32'd1);
        chk("hold_rd", EX_rd, 32'd9);
        chk("hold_a2", EX_a2, FWD_ON ? 32'hAB : 32'h11);
        step_cycle();

        // Flush beats hold
        set_id(5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 3'b000);
        step_cycle();
        set_id(5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 3'b000);
        EX_flush = 1'b1; EX_hold = 1'b1;
        #1;
        chk("flush_stall", ID_stall, 32'd0);
        step_cycle();
        idle();
        #1;
        chk("flush_valid", EX_valid, 32'd0);
        chk("flush_rd", EX_rd, 32'd0);
        step_cycle();

        // Asynchronous reset mid-stream
        set_id(5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 3'b100);
        step_cycle();
        idle();
        #1;
        chk("pre_rst_valid", EX_valid, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", EX_valid, 32'd0);
        chk("async_rst_rd", EX_rd, 32'd0);
        m = '0;
        step_cycle();
        rst = 1'b0;
        step_cycle();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs(exp_stall);
            step_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
